// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad entry slice.
//   - logical key codes (digits 0..9 map to their value)
//   - sign codes in the encoding the seven-segment display driver consumes
//   - scanner FSM state type
//   - helpers: row/column -> key map, single-low-bit detection/encoding
package keypad_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  localparam logic [2:0] SIGN_ADD = 3'b000;
  localparam logic [2:0] SIGN_SUB = 3'b001;
  localparam logic [2:0] SIGN_MUL = 3'b010;
  localparam logic [2:0] SIGN_DIV = 3'b011;
  localparam logic [2:0] SIGN_RST = 3'b100;
  localparam logic [2:0] SIGN_NUM = 3'b101;
  localparam logic [2:0] SIGN_EQ  = 3'b110;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

  // Physical layout:  1 2 3 + / 4 5 6 - / 7 8 9 * / C 0 = /
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'd1;    4'h1: code = 4'd2;  4'h2: code = 4'd3;   4'h3: code = KEY_ADD;
      4'h4: code = 4'd4;    4'h5: code = 4'd5;  4'h6: code = 4'd6;   4'h7: code = KEY_SUB;
      4'h8: code = 4'd7;    4'h9: code = 4'd8;  4'hA: code = 4'd9;   4'hB: code = KEY_MUL;
      4'hC: code = KEY_CLR; 4'hD: code = 4'd0;  4'hE: code = KEY_EQ; default: code = KEY_DIV;
    endcase
    return code;
  endfunction

  // True only when exactly one bit is low; multi-low patterns are ghosts.
  function automatic logic one_low(input logic [3:0] v);
    return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
  endfunction

  // Index of the low bit of a one-low pattern.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: column synchroniser, row scanner and debounce FSM.
//   clk, rst     : clock, synchronous active-high reset
//   col_in[3:0]  : raw active-low columns (asynchronous)
//   row_out[3:0] : active-low one-hot row drive
//   key_valid    : one-cycle pulse per accepted key event
//   key_code[3:0]: logical key code, valid with key_valid
// Optional KEYPAD_AUTOREPEAT_EN: digit keys re-pulse every REPEAT_CYCLES
// while held.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int SW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
  localparam int DW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [3:0]    sync1_q, col_s_q;
  state_e        state_q;
  logic [3:0]    row_out_q, lat_col_q, lat_code_q, key_code_q;
  logic [SW-1:0] scan_cnt_q;
  logic [DW-1:0] deb_cnt_q;
  logic          key_valid_q;
  logic [3:0]    row_next;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES < 2) ? 1 : $clog2(REPEAT_CYCLES);
  logic [RW-1:0] rep_cnt_q;
`endif

  // Rotate left: 1110 -> 1101 -> 1011 -> 0111 -> 1110
  assign row_next = {row_out_q[2:0], row_out_q[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 4'hF;
      col_s_q     <= 4'hF;
      state_q     <= SCAN;
      row_out_q   <= 4'b1110;
      lat_col_q   <= 4'hF;
      lat_code_q  <= '0;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      sync1_q     <= col_in;
      col_s_q     <= sync1_q;
      key_valid_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            if (one_low(col_s_q)) begin
              lat_col_q  <= col_s_q;
              lat_code_q <= key_map(low_idx(row_out_q), low_idx(col_s_q));
              deb_cnt_q  <= '0;
              state_q    <= DEBOUNCE;
            end else begin
              row_out_q <= row_next;
            end
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_s_q != lat_col_q) begin
            row_out_q  <= row_next;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            key_valid_q <= 1'b1;
            key_code_q  <= lat_code_q;
            deb_cnt_q   <= '0;
            state_q     <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        HELD: begin
          // Release needs an unbroken run of all-high samples.
          if (col_s_q != 4'hF) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_cnt_q  <= '0;
            row_out_q  <= row_next;
            scan_cnt_q <= '0;
            state_q    <= SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (col_s_q != lat_col_q) begin
            rep_cnt_q <= '0;
          end else if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
            rep_cnt_q <= '0;
            if (lat_code_q < KEY_ADD) begin
              key_valid_q <= 1'b1;
              key_code_q  <= lat_code_q;
            end
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign row_out   = row_out_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad scanner plus calculator entry register.
//   clk, rst     : clock, synchronous active-high reset
//   row_out[3:0] : active-low one-hot row drive
//   col_in[3:0]  : active-low columns (asynchronous)
//   key_valid    : one-cycle pulse per accepted key event
//   key_code[3:0]: logical key code, valid with key_valid
//   number[19:0] : entered operand 0..999999
//   sign[2:0]    : display mode/operator code
// Optional KEYPAD_AUTOREPEAT_EN (inside keypad_debounce): digit auto-repeat.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_out,
  input  logic [3:0]  col_in,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [19:0] number,
  output logic [2:0]  sign
);

  logic [19:0] number_q, times10;
  logic [2:0]  sign_q;

  keypad_debounce #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  // x*10 as shift-add; the <=99999 guard keeps the result below 2^20.
  assign times10 = (number_q << 3) + (number_q << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      number_q <= '0;
      sign_q   <= SIGN_RST;
    end else if (key_valid) begin
      case (key_code)
        KEY_ADD: begin number_q <= '0; sign_q <= SIGN_ADD; end
        KEY_SUB: begin number_q <= '0; sign_q <= SIGN_SUB; end
        KEY_MUL: begin number_q <= '0; sign_q <= SIGN_MUL; end
        KEY_DIV: begin number_q <= '0; sign_q <= SIGN_DIV; end
        KEY_CLR: begin number_q <= '0; sign_q <= SIGN_RST; end
        KEY_EQ:  sign_q <= SIGN_EQ;
        default: begin
          // Digit: a seventh digit is silently dropped.
          if (number_q <= 20'd99999) number_q <= times10 + {16'd0, key_code};
          sign_q <= SIGN_NUM;
        end
      endcase
    end
  end

  assign number = number_q;
  assign sign   = sign_q;

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;
  localparam int SD = 4, DB = 8, RP = 20;

  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  row_out, col_in, key_code;
  logic        key_valid;
  logic [19:0] number;
  logic [2:0]  sign;

  always #5 clk = ~clk;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clk(clk), .rst(rst), .row_out(row_out), .col_in(col_in),
    .key_valid(key_valid), .key_code(key_code), .number(number), .sign(sign));

  // Keypad matrix: pressed columns in row kr pull low while that row is driven.
  logic [1:0] kr = 2'd0;
  logic [3:0] kmask = 4'h0;
  always_comb col_in = (row_out[kr] == 1'b0) ? ~kmask : 4'hF;

  int errors = 0, checks = 0;
  int pulses = 0, cyc = 0, last_pulse_cyc = 0, last_code = 0;
  logic prev_vld = 1'b0;
  int mn = 0, ms = 4;   // reference entry state
  int lut [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  typedef struct { int r; int c; int code; int num; int sgn; } vec_t;
  vec_t tbl [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (key_valid) begin
      pulses++;
      last_code = key_code;
      last_pulse_cyc = cyc;
      check("kv_not_back_to_back", {31'd0, prev_vld}, 32'd0);
    end
    prev_vld = key_valid;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic model(input int k);
    if (k < 10) begin
      if (mn <= 99999) mn = mn * 10 + k;
      ms = 5;
    end else if (k <= 13) begin mn = 0; ms = k - 10; end
    else if (k == 14) begin mn = 0; ms = 4; end
    else ms = 6;
  endtask

  // Press until the first pulse, hold hold_after more cycles, release, settle.
  task automatic press(input int r, input int c, input int hold_after,
                       output int np, output int code);
    int p0, t;
    logic [3:0] rv;
    logic moved;
    p0 = pulses; kr = 2'(r); kmask = 4'(1 << c);
    t = 0;
    while (pulses == p0 && t < 300) begin tick(); t++; end
    if (pulses == p0) begin
      errors++; checks++;
      $display("FAIL press_timeout: got no key_valid for row %0d col %0d", r, c);
    end
    code = last_code;
    repeat (hold_after) tick();
    kmask = 4'h0;
    rv = ~(4'b0001 << r);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("row_held_after_release", {28'd0, row_out}, {28'd0, rv});
    end
    moved = 1'b0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (row_out != rv) moved = 1'b1;
    end
    check("scan_resumes", {31'd0, moved}, 32'd1);
    np = pulses - p0;
  endtask

  initial begin
    int np, code, p0, t, cnt, exp_np, changes, seed_r, seed_c;
    logic [3:0] er, lastrow;
    tbl[0]  = '{1, 2, 6, 6, 5};
    tbl[1]  = '{3, 0, 14, 0, 4};
    tbl[2]  = '{0, 0, 1, 1, 5};
    tbl[3]  = '{0, 1, 2, 12, 5};
    tbl[4]  = '{0, 2, 3, 123, 5};
    tbl[5]  = '{1, 0, 4, 1234, 5};
    tbl[6]  = '{1, 1, 5, 12345, 5};
    tbl[7]  = '{1, 2, 6, 123456, 5};
    tbl[8]  = '{2, 0, 7, 123456, 5};
    tbl[9]  = '{3, 2, 15, 123456, 6};
    tbl[10] = '{0, 3, 10, 0, 0};
    tbl[11] = '{3, 0, 14, 0, 4};

    // 1: reset values and idle scanning
    repeat (3) tick();
    rst = 1'b0;
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_number", {12'd0, number}, 32'd0);
    check("rst_sign", {29'd0, sign}, 32'd4);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      er = ~(4'b0001 << ((k / SD) % 4));
      check("idle_row_scan", {28'd0, row_out}, {28'd0, er});
    end
    check("idle_no_pulse", pulses, 0);

    // 2 and 4: directed key table
    for (int i = 0; i < 12; i++) begin
      press(tbl[i].r, tbl[i].c, 4, np, code);
      check("tbl_pulses", np, 1);
      check("tbl_code", code, tbl[i].code);
      check("tbl_number", {12'd0, number}, tbl[i].num);
      check("tbl_sign", {29'd0, sign}, tbl[i].sgn);
      model(tbl[i].code);
    end

    // 3: bouncing contact, then stable "2"
    p0 = pulses; kr = 2'd0;
    for (int i = 0; i < 12; i++) begin
      kmask = ((i / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
    end
    kmask = 4'b0010;
    cnt = cyc;
    t = 0;
    while (pulses == p0 && t < 300) begin tick(); t++; end
    check("bounce_pulse_seen", {31'd0, pulses != p0}, 32'd1);
    check("bounce_after_stable", {31'd0, (last_pulse_cyc - cnt) >= DB}, 32'd1);
    repeat (2) tick();
    kmask = 4'h0;
    repeat (30) tick();
    check("bounce_single_pulse", pulses - p0, 1);
    check("bounce_code", last_code, 2);
    model(2);
    check("bounce_number", {12'd0, number}, mn);

    // 5a: two columns in one row are rejected, scanning continues
    p0 = pulses; kr = 2'd2; kmask = 4'b0011;
    changes = 0; lastrow = row_out;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (row_out != lastrow) changes++;
      lastrow = row_out;
    end
    kmask = 4'h0;
    check("ghost_no_pulse", pulses - p0, 0);
    check("ghost_scanning", {31'd0, changes >= 10}, 32'd1);

    // 5b: reset mid-debounce of "4"
    p0 = pulses; kr = 2'd1; kmask = 4'b0001;
    cnt = 0; t = 0;
    while (cnt < 6 && t < 200) begin
      tick(); t++;
      cnt = (row_out == 4'b1101) ? cnt + 1 : 0;
    end
    check("debounce_reached", {31'd0, cnt >= 6}, 32'd1);
    rst = 1'b1; kmask = 4'h0;
    tick();
    check("midrst_row", {28'd0, row_out}, 32'hE);
    check("midrst_key_valid", {31'd0, key_valid}, 32'd0);
    check("midrst_key_code", {28'd0, key_code}, 32'd0);
    check("midrst_number", {12'd0, number}, 32'd0);
    check("midrst_sign", {29'd0, sign}, 32'd4);
    rst = 1'b0;
    repeat (20) tick();
    check("midrst_no_pulse", pulses - p0, 0);
    mn = 0; ms = 4;

    // 6: long holds of "9" and "*"
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_np = 1 + 62 / RP;
`else
    exp_np = 1;
`endif
    press(2, 2, 62, np, code);
    check("hold9_pulses", np, exp_np);
    check("hold9_code", code, 9);
    for (int i = 0; i < exp_np; i++) model(9);
    check("hold9_number", {12'd0, number}, mn);
    press(2, 3, 62, np, code);
    check("holdmul_pulses", np, 1);
    check("holdmul_code", code, 12);
    model(12);
    check("holdmul_sign", {29'd0, sign}, ms);

    // Random presses against the reference model
    for (int i = 0; i < 14; i++) begin
      seed_r = $urandom_range(0, 3);
      seed_c = (i % 3 == 2) ? $urandom_range(0, 3) : $urandom_range(0, 2);
      press(seed_r, seed_c, $urandom_range(2, 10), np, code);
      model(lut[seed_r][seed_c]);
      check("rnd_pulses", np, 1);
      check("rnd_code", code, lut[seed_r][seed_c]);
      check("rnd_number", {12'd0, number}, mn);
      check("rnd_sign", {29'd0, sign}, ms);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the seven-segment display driver.
- Scans a 4x4 matrix keypad, synchronises and debounces the column inputs, and decodes each press into a logical key.
- Maintains the calculator entry state as number[19:0] and sign[2:0], in the encoding the display driver consumes, so both connect directly.

Parameters:
- SCAN_DIV, 50000, clk cycles each row stays driven while scanning.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a press or a release.
- REPEAT_CYCLES, 25000000, hold time before the first auto-repeat and between repeats (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- row_out  out  4  keypad row drive, active-low one-hot
- col_in  in  4  keypad columns, active-low (pulled up externally), asynchronous
- key_valid  out  1  one-cycle pulse per accepted key event
- key_code  out  4  logical key code, valid while key_valid=1
- number  out  20  current entered operand, 0..999999
- sign  out  3  display mode/operator code

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: row_out=4'b1110; key_valid=0; key_code=0; number=0; sign=3'b100 (reset symbol); FSM=SCAN; all counters 0.
- Synchroniser:
  - col_in passes through 2 flops; col_s is the synchronised value.
  - Total latency col_in→col_s is 2 cycles.
- Key map, row r (row_out bit r low) and column c (col_s bit c low):
  - row0: 1, 2, 3, +
  - row1: 4, 5, 6, -
  - row2: 7, 8, 9, *
  - row3: C, 0, =, /
- Logical codes: digits 0-9 = 0..9; + = 10; - = 11; * = 12; / = 13; C = 14; = = 15.
- Column validity: a col_s with more than one low bit is "no key" (ghost/multi-press rejection).
- FSM:
  - SCAN:
    - Scan counter counts 0..SCAN_DIV-1.
    - At terminal count, if col_s has exactly one low bit: latch row and column, go DEBOUNCE, clear debounce counter.
    - Otherwise rotate row_out left (1110→1101→1011→0111→1110) and restart the count.
  - DEBOUNCE:
    - Row is held.
    - If col_s differs from the latched pattern: go SCAN and advance the row.
    - If the counter reaches DEBOUNCE_CYCLES-1: pulse key_valid with the decoded key_code for 1 cycle, apply the entry update in that same cycle, go HELD.
  - HELD:
    - Row is held.
    - Counter clears whenever col_s != 4'b1111.
    - After DEBOUNCE_CYCLES consecutive all-high cycles: go SCAN, advance the row.
- Entry update, registered in the key_valid cycle:
  - digit d: if number <= 99999 then number <= number*10+d, else number is unchanged (overflow ignored). sign <= 3'b101 in both cases.
  - + - * /: sign <= 3'b000, 001, 010, 011 respectively; number <= 0.
  - C: number <= 0; sign <= 3'b100.
  - =: sign <= 3'b110; number unchanged.
- Arithmetic: number*10 is computed as (number<<3)+(number<<1) at 20-bit width; the guard guarantees the result ≤ 999999 with no wrap.
- Timing: key_valid is never asserted on consecutive cycles. Press-to-pulse latency is 2 + DEBOUNCE_CYCLES cycles after the scan hit.
- rst asserted in any state wins over every other update on that edge.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs while the same column stays low.
  - Each time it reaches REPEAT_CYCLES-1, key_valid re-pulses with the same key_code and the counter restarts.
  - Repeat applies to digit keys only; other keys never repeat.
  - Releasing the key clears the counter.
- Undefined: exactly one key_valid per press; the repeat counter is absent.

Decomposition:
- Shared package keypad_pkg holds:
  - key code constants (KEY_ADD=10 … KEY_EQ=15);
  - sign constants (SIGN_ADD=3'b000, SIGN_SUB=3'b001, SIGN_MUL=3'b010, SIGN_DIV=3'b011, SIGN_RST=3'b100, SIGN_NUM=3'b101, SIGN_EQ=3'b110);
  - FSM state enum {SCAN, DEBOUNCE, HELD};
  - the 16-entry row/column→code map function.
- Sub-module keypad_debounce: synchroniser + FSM + row scan, emitting key_valid/key_code.
- Top level: entry-update register logic.

Test Plan:
Benches use SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20.
1. Reset release, no keys (col_in=1111) → row_out cycles 1110,1101,1011,0111 every 4 cycles; number=0, sign=100, no key_valid.
2. Press row1/col2 ("6") held 30 cycles, then released → exactly one key_valid, key_code=6; number=6, sign=101; scanning resumes ≥8 cycles after release.
3. Key bounces (toggles every 3 cycles for 12 cycles), then stable → only one key_valid, issued after 8 stable cycles.
4. Enter 1,2,3,4,5,6,7 → number=123456 after six presses; seventh press pulses key_valid, number stays 123456; then "+" → sign=000, number=0; then "C" → sign=100, number=0.
5. Two columns low in the same row → no key_valid, scanning continues; rst asserted mid-DEBOUNCE → all outputs at reset values on the next cycle.
6. KEYPAD_AUTOREPEAT_EN defined: "9" held 70 cycles → key_valid count = 1 + floor((70-8)/20) = 4. "*" held 70 cycles → count = 1.
